// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
package lsu_pkg;

  // funct3 access-size encodings shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication,
// misalignment detection, and load lane select with sign/zero extension.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte and halfword out of the returned word
  always_comb begin
    lane_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent enables, replication, alignment check and extension
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = |addr_lo;
    load_data  = rdata;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        misaligned = 1'b0;
        load_data  = (funct3 == F3_B) ? {{24{lane_byte[7]}}, lane_byte}
                                      : {24'h000000, lane_byte};
      end
      F3_H, F3_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
        load_data  = (funct3 == F3_H) ? {{16{lane_half[15]}}, lane_half}
                                      : {16'h0000, lane_half};
      end
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = |addr_lo;
        load_data  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a single-outstanding req/gnt/rvalid
// data bus and produces the MEM/WB slot, bubbling it while stalled.
module mem_stage_lsu #(
  parameter int unsigned RESP_TIMEOUT = 255,
  parameter int unsigned TMO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        wb_reg_file_in,
  input  logic        memtoreg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] load_data_out,
  output logic [4:0]  rd_out,
  output logic        wb_reg_file_out,
  output logic        memtoreg_out,
  output logic        misalign_err,
  output logic        bus_err
);

  import lsu_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

  lsu_state_e       state;
  logic [31:0]      load_buf;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_err;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        bubble;
  logic [31:0] ext_data;

  assign is_load  = valid_in & mem_read_in;
  assign is_store = valid_in & mem_write_in & ~mem_read_in;
  assign mem_op   = is_load | is_store;
  assign access   = mem_op & ~misaligned;

  lsu_data_align u_align (
    .funct3     (funct3_in),
    .addr_lo    (alu_result_in[1:0]),
    .store_data (store_data_in),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .misaligned (misaligned),
    .load_data  (ext_data)
  );

  assign dmem_addr      = {alu_result_in[31:2], 2'b00};
  assign dmem_we        = dmem_req & is_store;
  assign alu_result_out = alu_result_in;
  assign rd_out         = rd_in;
  assign wb_reg_file_out = wb_reg_file_in & ~bubble;
  assign memtoreg_out    = memtoreg_in & ~bubble;

  // Bus request, stall and bubble decode; reset forces the idle bubble
  always_comb begin
    dmem_req      = 1'b0;
    stall_out     = 1'b0;
    bubble        = 1'b0;
    load_data_out = ZERO32;
    case (state)
      S_IDLE: begin
        if (access) begin
          dmem_req  = 1'b1;
          stall_out = is_load | ~dmem_gnt;
          bubble    = 1'b1;
        end else if (!valid_in || mem_op) begin
          bubble = 1'b1;
        end
      end
      S_REQ: begin
        dmem_req  = 1'b1;
        stall_out = is_load | ~dmem_gnt;
        bubble    = 1'b1;
      end
      S_RESP: begin
        stall_out = 1'b1;
        bubble    = 1'b1;
      end
      S_DONE: begin
        load_data_out = load_buf;
        bubble        = done_err | ~valid_in;
      end
      default: bubble = 1'b1;
    endcase
    if (rst) begin
      dmem_req      = 1'b0;
      stall_out     = 1'b0;
      bubble        = 1'b1;
      load_data_out = ZERO32;
    end
  end

  // Access FSM, response timeout, load buffer and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      load_buf     <= ZERO32;
      tmo_cnt      <= '0;
      done_err     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= (state == S_IDLE) & mem_op & misaligned;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (is_load && dmem_gnt) begin
              state   <= S_RESP;
              tmo_cnt <= '0;
            end else if (!dmem_gnt) begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            if (is_load) begin
              state   <= S_RESP;
              tmo_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            load_buf <= ext_data;
            done_err <= 1'b0;
            state    <= S_DONE;
          end else if (tmo_cnt >= TMO_LAST) begin
            load_buf <= ZERO32;
            done_err <= 1'b1;
            bus_err  <= 1'b1;
            state    <= S_DONE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DONE: begin
          done_err <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a byte-addressed reference memory
// predicts each retired MEM/WB slot; a bus slave with random grant/response
// latency backs the DUT; a monitor compares every retiring slot.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        wb_reg_file_in = 1'b0;
  logic        memtoreg_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_out;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic [4:0]  rd_out;
  logic        wb_reg_file_out;
  logic        memtoreg_out;
  logic        misalign_err;
  logic        bus_err;

  mem_stage_lsu #(.RESP_TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .wb_reg_file_in(wb_reg_file_in),
    .memtoreg_in(memtoreg_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .alu_result_out(alu_result_out), .load_data_out(load_data_out), .rd_out(rd_out),
    .wb_reg_file_out(wb_reg_file_out), .memtoreg_out(memtoreg_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit          rd_op;
    bit          wr_op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
    bit          wb;
    int unsigned gd;
    int unsigned rv;
    bit          drop;
  } slot_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    bit          wb;
    bit          mtr;
    bit          ck_ld;
    bit          ck_mtr;
    bit          mis;
    bit          berr;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  exp_t        exp_q[$];

  logic [7:0]  ref_mem[int unsigned];
  logic [31:0] bus_mem[int unsigned];

  int unsigned cfg_gnt = 0;
  int unsigned cfg_rv = 0;
  bit          cfg_drop = 1'b0;
  int unsigned stray_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic void poke_word(input int unsigned addr, input logic [31:0] w);
    bus_mem[addr / 4] = w;
    for (int unsigned k = 0; k < 4; k++) ref_mem[addr + k] = 8'(w >> (8 * k));
  endfunction

  // Reference model: architectural effect of one EX/MEM slot
  function automatic exp_t predict(input slot_t s);
    exp_t e;
    int unsigned sz;
    logic [31:0] w;
    e.alu = s.a; e.rd = s.rd; e.ld = '0; e.mtr = 1'b0; e.ck_ld = 1'b1; e.ck_mtr = 1'b1;
    e.mis = 1'b0; e.berr = 1'b0; e.wb = s.valid && s.wb;
    if (s.valid && (s.rd_op || s.wr_op)) begin
      sz = size_of(s.f3);
      if (s.a % sz != 0) begin
        e.mis = 1'b1; e.wb = 1'b0; e.ck_ld = 1'b0; e.ck_mtr = 1'b0;
      end else if (s.rd_op) begin
        if (s.drop) begin
          e.berr = 1'b1; e.wb = 1'b0; e.ck_ld = 1'b0; e.ck_mtr = 1'b0;
        end else begin
          w = '0;
          for (int unsigned k = 0; k < sz; k++) w = w + (32'(ref_mem[s.a + k]) << (8 * k));
          if (s.f3 == 3'd0 && w >= 128) w = w - 256;
          if (s.f3 == 3'd1 && w >= 32768) w = w - 65536;
          e.ld = w; e.mtr = 1'b1;
        end
      end else begin
        e.wb = 1'b0; e.ck_ld = 1'b0;
        for (int unsigned k = 0; k < sz; k++) ref_mem[s.a + k] = 8'(s.d >> (8 * k));
      end
    end
    return e;
  endfunction

  // Bus slave: grants after cfg_gnt cycles, answers reads cfg_rv cycles later
  bit          req_act = 1'b0;
  int unsigned g_cnt = 0;
  bit          pend = 1'b0;
  bit          pend_drop = 1'b0;
  int unsigned rv_cnt = 0;
  int unsigned pend_idx = 0;
  int unsigned stray_done = 0;
  always @(posedge clk) begin
    #2;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = $urandom;
    if (rst) begin
      pend = 1'b0;
      req_act = 1'b0;
    end else begin
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hA5A5_A5A5;
      end else if (pend) begin
        if (rv_cnt == 0) begin
          pend = 1'b0;
          if (!pend_drop) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = bus_mem[pend_idx];
          end
        end else rv_cnt--;
      end
      if (dmem_req) begin
        if (!req_act) begin
          req_act = 1'b1;
          g_cnt = cfg_gnt;
        end
        if (g_cnt == 0) begin
          dmem_gnt = 1'b1;
          req_act = 1'b0;
          if (dmem_we) begin
            for (int unsigned k = 0; k < 4; k++)
              if (dmem_be[k]) bus_mem[dmem_addr / 4][8 * k +: 8] = dmem_wdata[8 * k +: 8];
          end else begin
            pend = 1'b1;
            rv_cnt = cfg_rv;
            pend_drop = cfg_drop;
            pend_idx = dmem_addr / 4;
          end
        end else g_cnt--;
      end
    end
  end

  // Monitor: pop and compare on every non-stalled cycle, track error pulses
  exp_t mon_e;
  bit   mis_pending = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mis_pending = 1'b0;
    end else begin
      chk("misalign_err", 32'(misalign_err), 32'(mis_pending));
      mis_pending = 1'b0;
      if (stall_out) begin
        chk("wb_during_stall", 32'(wb_reg_file_out), 32'd0);
        chk("bus_err_during_stall", 32'(bus_err), 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ret_alu_result", alu_result_out, mon_e.alu);
        chk("ret_rd", 32'(rd_out), 32'(mon_e.rd));
        chk("ret_wb_reg_file", 32'(wb_reg_file_out), 32'(mon_e.wb));
        if (mon_e.ck_ld) chk("ret_load_data", load_data_out, mon_e.ld);
        if (mon_e.ck_mtr) chk("ret_memtoreg", 32'(memtoreg_out), 32'(mon_e.mtr));
        chk("ret_bus_err", 32'(bus_err), 32'(mon_e.berr));
        mis_pending = mon_e.mis;
      end
    end
  end

  // Present one slot, hold it until it retires, report what the bus saw
  task automatic issue_slot(input slot_t s, output int unsigned n_stall,
                            output int unsigned n_req, output bit stable,
                            output logic [3:0] be0, output logic [31:0] wd0,
                            output logic [31:0] ld_ret);
    bit done;
    logic [31:0] ad0;
    cfg_gnt = s.gd; cfg_rv = s.rv; cfg_drop = s.drop;
    exp_q.push_back(predict(s));
    valid_in = s.valid; alu_result_in = s.a; store_data_in = s.d; rd_in = s.rd;
    wb_reg_file_in = s.wb; memtoreg_in = s.valid && s.rd_op;
    mem_read_in = s.rd_op; mem_write_in = s.wr_op; funct3_in = s.f3;
    n_stall = 0; n_req = 0; stable = 1'b1; be0 = '0; wd0 = '0; ad0 = '0; ld_ret = '0;
    done = 1'b0;
    for (int unsigned cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      if (dmem_req) begin
        if (n_req == 0) begin
          be0 = dmem_be; wd0 = dmem_wdata; ad0 = dmem_addr;
        end else if (dmem_be !== be0 || dmem_wdata !== wd0 || dmem_addr !== ad0) begin
          stable = 1'b0;
        end
        n_req++;
      end
      if (stall_out) n_stall++;
      else begin
        done = 1'b1;
        ld_ret = load_data_out;
      end
    end
    if (!done) chk("slot_retire_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic slot_t mk(input bit valid, input bit rd_op, input bit wr_op,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input int unsigned gd,
                               input int unsigned rv, input bit drop);
    slot_t s;
    s.valid = valid; s.rd_op = rd_op; s.wr_op = wr_op; s.f3 = f3; s.a = a; s.d = d;
    s.rd = 5'(a[6:2] + 1); s.wb = rd_op || (!wr_op); s.gd = gd; s.rv = rv; s.drop = drop;
    return s;
  endfunction

  initial begin
    int unsigned ns, nr;
    bit st;
    logic [3:0] b0;
    logic [31:0] w0, ld;
    slot_t s;
    int unsigned kind, sz;

    for (int unsigned i = 0; i < 16; i++) poke_word(32'h100 + 4 * i, $urandom);
    poke_word(32'h100, 32'hDEAD_BEEF);
    poke_word(32'h200, 32'h8011_2233);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb", 32'(wb_reg_file_out), 32'd0);
    chk("rst_memtoreg", 32'(memtoreg_out), 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    chk("rst_misalign_err", 32'(misalign_err), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // LW with same-cycle grant and next-cycle response
    issue_slot(mk(1, 1, 0, 3'd2, 32'h100, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);
    chk("lw_stall_cycles", 32'(ns), 32'd2);
    chk("lw_data", ld, 32'hDEAD_BEEF);

    // Byte/half lane extension
    issue_slot(mk(1, 1, 0, 3'd0, 32'h203, 0, 1, 1, 0), ns, nr, st, b0, w0, ld);
    chk("lb_data", ld, 32'hFFFF_FF80);
    issue_slot(mk(1, 1, 0, 3'd4, 32'h203, 0, 0, 2, 0), ns, nr, st, b0, w0, ld);
    chk("lbu_data", ld, 32'h0000_0080);
    issue_slot(mk(1, 1, 0, 3'd5, 32'h202, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);
    chk("lhu_data", ld, 32'h0000_8011);

    // SH with grant delayed two cycles, then read it back
    issue_slot(mk(1, 0, 1, 3'd1, 32'h102, 32'h0000_ABCD, 2, 0, 0), ns, nr, st, b0, w0, ld);
    chk("sh_be", 32'(b0), 32'(4'b1100));
    chk("sh_wdata", w0, 32'hABCD_ABCD);
    chk("sh_req_cycles", 32'(nr), 32'd3);
    chk("sh_bus_stable", 32'(st), 32'd1);
    chk("sh_stall_cycles", 32'(ns), 32'd2);
    issue_slot(mk(1, 1, 0, 3'd2, 32'h100, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);
    chk("sh_readback", ld, 32'hABCD_BEEF);

    // Misaligned LW: no request, no stall
    issue_slot(mk(1, 1, 0, 3'd2, 32'h101, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);
    chk("mis_req_cycles", 32'(nr), 32'd0);
    chk("mis_stall_cycles", 32'(ns), 32'd0);
    issue_slot(mk(1, 0, 0, 3'd0, 32'h1234_5678, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);

    // Response timeout, then a stray rvalid that must be ignored
    issue_slot(mk(1, 1, 0, 3'd2, 32'h104, 0, 0, 0, 1), ns, nr, st, b0, w0, ld);
    chk("tmo_stall_cycles", 32'(ns), 32'd5);
    stray_req++;
    issue_slot(mk(1, 0, 0, 3'd0, 32'h0BAD_F00D, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);
    issue_slot(mk(1, 1, 0, 3'd2, 32'h104, 0, 0, 1, 0), ns, nr, st, b0, w0, ld);

    // Reset while waiting for the response
    cfg_gnt = 0; cfg_drop = 1'b1;
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; memtoreg_in = 1'b1;
    funct3_in = 3'd2; alu_result_in = 32'h108; wb_reg_file_in = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0; memtoreg_in = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    stray_req++;
    issue_slot(mk(0, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);
    chk("postrst_stall", 32'(ns), 32'd0);
    chk("postrst_req", 32'(nr), 32'd0);
    chk("postrst_load_data", ld, 32'd0);
    issue_slot(mk(1, 0, 0, 3'd0, 32'hCAFE_0000, 0, 0, 0, 0), ns, nr, st, b0, w0, ld);

    // Randomized mix of idle, ALU, load and store slots
    for (int unsigned i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      s.valid = (kind != 0);
      s.rd_op = (kind >= 3 && kind <= 6);
      s.wr_op = (kind >= 7);
      s.f3 = s.wr_op ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      sz = size_of(s.f3);
      if (s.rd_op || s.wr_op) begin
        s.a = 32'h100 + $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0) s.a = s.a - (s.a % sz);
      end else s.a = $urandom;
      s.d = $urandom; s.rd = 5'($urandom); s.wb = 1'($urandom);
      s.gd = $urandom_range(0, 2); s.rv = $urandom_range(0, 2);
      s.drop = ($urandom_range(0, 9) == 0);
      issue_slot(s, ns, nr, st, b0, w0, ld);
      if ((s.rd_op || s.wr_op) && s.valid) chk("rand_bus_stable", 32'(st), 32'd1);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit and producer side of the MEM/WB register.
- Takes EX/MEM control and address, and drives a single-outstanding req/gnt/rvalid data-memory bus.
- Aligns and extends load data, then presents alu_result/load_data/rd/wb_reg_file/memtoreg to the MEM/WB register.
- Because MEM/WB captures every cycle, this block presents a bubble (wb_reg_file_out=0) whenever it stalls.

Parameters:
- RESP_TIMEOUT, 255: maximum cycles in S_RESP before the access is abandoned with bus_err.
- TMO_W, 8: width of the timeout counter; must satisfy 2^TMO_W > RESP_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  EX/MEM slot holds a real instruction.
- alu_result_in  in  32  ALU result; this is the effective address for memory ops.
- store_data_in  in  32  rs2 value for stores.
- rd_in  in  5  destination register.
- wb_reg_file_in  in  1  register-file write enable.
- memtoreg_in  in  1  writeback selects load data.
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- funct3_in  in  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010).
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- stall_out  out  1  hold PC/IF/ID/EX and EX/MEM.
- alu_result_out  out  32  to MEM/WB.
- load_data_out  out  32  to MEM/WB.
- rd_out  out  5  to MEM/WB.
- wb_reg_file_out  out  1  to MEM/WB.
- memtoreg_out  out  1  to MEM/WB.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on a response timeout.

Behaviour:
- FSM states:
  - S_IDLE: no access outstanding.
  - S_REQ: request asserted, waiting for gnt.
  - S_RESP: load granted, waiting for rvalid.
  - S_DONE: buffered load result presented.
- Reset (synchronous): state=S_IDLE, load_buf=0, timeout counter=0, error pulses=0, dmem_req=0. Outputs settle to the bubble: wb_reg_file_out=0, memtoreg_out=0, load_data_out=0, stall_out=0.
- Non-memory op, or valid_in=0, in S_IDLE:
  - Zero-latency combinational pass-through; load_data_out=0; stall_out=0.
  - If valid_in=0, wb_reg_file_out is forced to 0.
- Misalignment:
  - Conditions: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Response: misalign_err pulses, no bus request, wb_reg_file_out=0, no stall.
- Load in S_IDLE:
  - dmem_req=1 and stall_out=1 combinationally.
  - gnt in the same cycle -> S_RESP; otherwise -> S_REQ.
- S_REQ:
  - Hold req/addr/we/be/wdata stable; stall_out=1; present a bubble.
  - gnt -> S_RESP for a load, S_IDLE for a store.
- S_RESP:
  - stall_out=1; present a bubble; count cycles.
  - rvalid -> capture the aligned/extended rdata into load_buf, go to S_DONE.
  - Count reaching RESP_TIMEOUT -> bus_err pulse, go to S_DONE with wb suppressed.
- S_DONE:
  - stall_out=0; present load_buf with the instruction fields (held stable by the stall); wb_reg_file_out as issued.
  - Next state S_IDLE.
- Minimum load latency is 3 cycles (issue, rvalid, present).
- Stores:
  - stall_out = !dmem_gnt.
  - Store granted in S_IDLE completes with no stall and wb_reg_file_out=0.
- Byte enables:
  - SB: be = 1<<addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011 or 1100 by addr[1], wdata = {2{half}}.
  - SW: be = 1111.
- Load extension:
  - LB/LH sign-extend; LBU/LHU zero-extend the lane selected by addr[1:0].
  - Unknown funct3 is treated as LW.
- rvalid in S_IDLE, S_REQ or S_DONE is ignored.
- Reset mid-access: the FSM drops to S_IDLE at once; a late rvalid is ignored.
- Counter saturates; it clears on entry to S_RESP.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum (S_IDLE, S_REQ, S_RESP, S_DONE).
  - The ZERO32 constant.
- Natural sub-module: lsu_data_align, purely combinational. It computes be/wdata replication, misalign detection and load lane select/extension, and is instantiated once.

Test Plan:
- LW at 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF:
  - stall_out high for 2 cycles.
  - Third cycle shows load_data_out=0xDEADBEEF, wb_reg_file_out=1, memtoreg_out=1.
- LB at 0x203, rdata=0x80112233 -> load_data_out=0xFFFFFF80.
- LBU at 0x203, same rdata -> load_data_out=0x00000080.
- LHU at 0x202 -> load_data_out=0x00008011.
- SH at 0x102, data=0x0000ABCD, gnt delayed 2 cycles:
  - dmem_be=1100, dmem_wdata=0xABCDABCD, stable for 3 cycles.
  - stall_out=1 for 2 cycles.
  - wb_reg_file_out=0 throughout.
- LW at 0x101 -> misalign_err pulse, dmem_req never asserted, wb_reg_file_out=0, stall_out=0.
- LW granted, no rvalid, RESP_TIMEOUT=4:
  - bus_err pulses after 4 cycles in S_RESP.
  - Next cycle wb_reg_file_out=0, stall_out=0.
  - A later stray rvalid is ignored.
- rst asserted while in S_RESP:
  - Next cycle dmem_req=0, stall_out=0, state S_IDLE.
  - A following rvalid leaves load_data_out=0.
